// File: rtl/ctrl_encode_def.sv
// Control encodings shared by the multicycle controller, its ALU decoder and the datapath.
package ctrl_encode_def;

    typedef enum logic [3:0] {
        StFetch,
        StDcd,
        StExe,
        StBranch,
        StJmp,
        StMa,
        StMr,
        StMw,
        StWb,
        StMemwb,
        StTrap
    } state_e;

    typedef enum logic [1:0] {
        CauseNone    = 2'd0,
        CauseIllegal = 2'd1,
        CauseImemTo  = 2'd2,
        CauseDmemTo  = 2'd3
    } cause_e;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JMPR   = 2'd3;

    localparam logic [1:0] GPRSel_RD = 2'd0;
    localparam logic [1:0] GPRSel_RT = 2'd1;
    localparam logic [1:0] GPRSel_31 = 2'd2;

    localparam logic [1:0] WDSel_FromALU = 2'd0;
    localparam logic [1:0] WDSel_FromMEM = 2'd1;
    localparam logic [1:0] WDSel_FromPC  = 2'd2;

    localparam logic [1:0] EXT_UNSIGNED = 2'd0;
    localparam logic [1:0] EXT_SIGNED   = 2'd1;

    localparam logic [1:0] ASEL_RS    = 2'd0;
    localparam logic [1:0] ASEL_C16   = 2'd1;
    localparam logic [1:0] ASEL_SHIFT = 2'd2;

    localparam logic BSEL_RT  = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    localparam logic [4:0] ALUOp_NOP  = 5'd0;
    localparam logic [4:0] ALUOp_ADD  = 5'd1;
    localparam logic [4:0] ALUOp_ADDU = 5'd2;
    localparam logic [4:0] ALUOp_SUB  = 5'd3;
    localparam logic [4:0] ALUOp_SUBU = 5'd4;
    localparam logic [4:0] ALUOp_AND  = 5'd5;
    localparam logic [4:0] ALUOp_OR   = 5'd6;
    localparam logic [4:0] ALUOp_NOR  = 5'd7;
    localparam logic [4:0] ALUOp_XOR  = 5'd8;
    localparam logic [4:0] ALUOp_SLT  = 5'd9;
    localparam logic [4:0] ALUOp_SLTU = 5'd10;
    localparam logic [4:0] ALUOp_EQL  = 5'd11;
    localparam logic [4:0] ALUOp_SLL  = 5'd12;
    localparam logic [4:0] ALUOp_SRL  = 5'd13;
    localparam logic [4:0] ALUOp_SRA  = 5'd14;
    localparam logic [4:0] ALUOp_SLLV = 5'd15;
    localparam logic [4:0] ALUOp_SRLV = 5'd16;
    localparam logic [4:0] ALUOp_SRAV = 5'd17;

endpackage

// File: rtl/instruction_def.sv
// MIPS opcode and funct field codes plus opcode class helpers.
package instruction_def;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    function automatic logic is_itype_alu(input logic [5:0] op);
        return (op >= OP_ADDI) && (op <= OP_LUI);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) ||
               (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU-control decode for the EXE step: op/funct to alu_op and operand selects.
module mc_alu_dec
    import ctrl_encode_def::*;
    import instruction_def::*;
#(
    parameter int unsigned ALUOP_W = 5
) (
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         a_sel,
    output logic               b_sel,
    output logic [1:0]         ext_op
);

    logic [4:0] code;

    always_comb begin
        code   = ALUOp_NOP;
        a_sel  = ASEL_RS;
        b_sel  = BSEL_RT;
        ext_op = EXT_UNSIGNED;
        if (op == OP_RTYPE) begin
            case (funct)
                F_ADD:  code = ALUOp_ADD;
                F_ADDU: code = ALUOp_ADDU;
                F_SUB:  code = ALUOp_SUB;
                F_SUBU: code = ALUOp_SUBU;
                F_AND:  code = ALUOp_AND;
                F_OR:   code = ALUOp_OR;
                F_XOR:  code = ALUOp_XOR;
                F_NOR:  code = ALUOp_NOR;
                F_SLT:  code = ALUOp_SLT;
                F_SLTU: code = ALUOp_SLTU;
                F_SLL:  begin code = ALUOp_SLL;  a_sel = ASEL_SHIFT; end
                F_SRL:  begin code = ALUOp_SRL;  a_sel = ASEL_SHIFT; end
                F_SRA:  begin code = ALUOp_SRA;  a_sel = ASEL_SHIFT; end
                F_SLLV: begin code = ALUOp_SLLV; a_sel = ASEL_SHIFT; end
                F_SRLV: begin code = ALUOp_SRLV; a_sel = ASEL_SHIFT; end
                F_SRAV: begin code = ALUOp_SRAV; a_sel = ASEL_SHIFT; end
                default: code = ALUOp_NOP;
            endcase
        end else if (is_itype_alu(op)) begin
            b_sel = BSEL_IMM;
            case (op)
                OP_ADDI:  code = ALUOp_ADD;
                OP_ADDIU: code = ALUOp_ADDU;
                OP_SLTI:  code = ALUOp_SLT;
                OP_SLTIU: code = ALUOp_SLTU;
                OP_ANDI:  code = ALUOp_AND;
                OP_ORI:   code = ALUOp_OR;
                OP_XORI:  code = ALUOp_XOR;
                // LUI shifts the immediate left by the constant 16 on the A port.
                OP_LUI:   begin code = ALUOp_SLL; a_sel = ASEL_C16; end
                default:  code = ALUOp_NOP;
            endcase
        end
    end

    assign alu_op = ALUOP_W'(code);

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with req/ack memory handshakes, ack timeout and sticky trap.
module mc_ctrl_hs
    import ctrl_encode_def::*;
    import instruction_def::*;
#(
    parameter int unsigned ALUOP_W      = 5,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               pc_wr,
    output logic [1:0]         npc_op,
    output logic               ir_wr,
    output logic               rf_wr,
    output logic [1:0]         gpr_sel,
    output logic [1:0]         wd_sel,
    output logic               dm_wr,
    output logic [1:0]         ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         a_sel,
    output logic               b_sel,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    localparam int unsigned    CntW   = $clog2(MEM_TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            trap_q, trap_d;
    cause_e          cause_q, cause_d;

    logic [ALUOP_W-1:0] dec_alu_op;
    logic [1:0]         dec_a_sel;
    logic               dec_b_sel;
    logic [1:0]         dec_ext_op;

    mc_alu_dec #(
        .ALUOP_W(ALUOP_W)
    ) u_alu_dec (
        .op    (op),
        .funct (funct),
        .alu_op(dec_alu_op),
        .a_sel (dec_a_sel),
        .b_sel (dec_b_sel),
        .ext_op(dec_ext_op)
    );

    logic is_r, is_jr, is_jalr, timed_out;
    assign is_r      = (op == OP_RTYPE);
    assign is_jr     = is_r && (funct == F_JR);
    assign is_jalr   = is_r && (funct == F_JALR);
    assign timed_out = (cnt_q == CntMax);

    always_comb begin
        state_d  = state_q;
        trap_d   = trap_q;
        cause_d  = cause_q;
        pc_wr    = 1'b0;
        npc_op   = NPC_PLUS4;
        ir_wr    = 1'b0;
        rf_wr    = 1'b0;
        gpr_sel  = GPRSel_RD;
        wd_sel   = WDSel_FromALU;
        dm_wr    = 1'b0;
        ext_op   = EXT_UNSIGNED;
        alu_op   = '0;
        a_sel    = ASEL_RS;
        b_sel    = BSEL_RT;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = StDcd;
                end else if (timed_out) begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseImemTo;
                end
            end
            StDcd: begin
                if (is_r || is_itype_alu(op))          state_d = StExe;
                else if (is_load(op) || is_store(op))  state_d = StMa;
                else if (op == OP_BEQ || op == OP_BNE) state_d = StBranch;
                else if (op == OP_J || op == OP_JAL)   state_d = StJmp;
                else if (ILLEGAL_TRAP) begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseIllegal;
                end else begin
                    state_d = StFetch;
                end
            end
            StExe: begin
                alu_op = dec_alu_op;
                a_sel  = dec_a_sel;
                b_sel  = dec_b_sel;
                ext_op = dec_ext_op;
                if (is_jr || is_jalr) begin
                    pc_wr   = 1'b1;
                    npc_op  = NPC_JMPR;
                    rf_wr   = is_jalr;
                    wd_sel  = is_jalr ? WDSel_FromPC : WDSel_FromALU;
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StBranch: begin
                alu_op  = ALUOP_W'(ALUOp_EQL);
                ext_op  = EXT_SIGNED;
                npc_op  = NPC_BRANCH;
                pc_wr   = (op == OP_BNE) ? ~zero : zero;
                state_d = StFetch;
            end
            StJmp: begin
                pc_wr  = 1'b1;
                npc_op = NPC_JUMP;
                if (op == OP_JAL) begin
                    rf_wr   = 1'b1;
                    gpr_sel = GPRSel_31;
                    wd_sel  = WDSel_FromPC;
                end
                state_d = StFetch;
            end
            StMa: begin
                alu_op  = ALUOP_W'(ALUOp_ADDU);
                b_sel   = BSEL_IMM;
                ext_op  = EXT_SIGNED;
                state_d = is_load(op) ? StMr : StMw;
            end
            StMr, StMw: begin
                dmem_req = 1'b1;
                dm_wr    = (state_q == StMw);
                if (dmem_ack) begin
                    state_d = (state_q == StMr) ? StMemwb : StFetch;
                end else if (timed_out) begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseDmemTo;
                end
            end
            StWb: begin
                rf_wr   = 1'b1;
                gpr_sel = is_r ? GPRSel_RD : GPRSel_RT;
                state_d = StFetch;
            end
            StMemwb: begin
                rf_wr   = 1'b1;
                gpr_sel = GPRSel_RT;
                wd_sel  = WDSel_FromMEM;
                state_d = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Wait counter restarts on every state change and saturates at the timeout value.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((imem_req || dmem_req) && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: expectations queued per cycle and checked as outputs settle.
module tb_mc_ctrl_hs;
    import ctrl_encode_def::*;
    import instruction_def::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;

    logic       pc_wr, ir_wr, rf_wr, dm_wr, b_sel, imem_req, dmem_req, trap;
    logic [1:0] npc_op, gpr_sel, wd_sel, ext_op, a_sel, trap_cause;
    logic [4:0] alu_op;

    logic       s_pc_wr, s_ir_wr, s_rf_wr, s_dm_wr, s_b_sel, s_imem_req, s_dmem_req, s_trap;
    logic [1:0] s_npc_op, s_gpr_sel, s_wd_sel, s_ext_op, s_a_sel, s_trap_cause;
    logic [4:0] s_alu_op;

    always #5 clk = ~clk;

    mc_ctrl_hs #(.ALUOP_W(5), .MEM_TIMEOUT(16), .ILLEGAL_TRAP(1'b1)) u_dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .pc_wr(pc_wr), .npc_op(npc_op),
        .ir_wr(ir_wr), .rf_wr(rf_wr), .gpr_sel(gpr_sel), .wd_sel(wd_sel), .dm_wr(dm_wr),
        .ext_op(ext_op), .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel),
        .imem_req(imem_req), .dmem_req(dmem_req), .trap(trap), .trap_cause(trap_cause)
    );

    // Second instance runs the same stimulus with unknown opcodes skipped instead of trapped.
    mc_ctrl_hs #(.ALUOP_W(5), .MEM_TIMEOUT(16), .ILLEGAL_TRAP(1'b0)) u_skip (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .pc_wr(s_pc_wr), .npc_op(s_npc_op),
        .ir_wr(s_ir_wr), .rf_wr(s_rf_wr), .gpr_sel(s_gpr_sel), .wd_sel(s_wd_sel),
        .dm_wr(s_dm_wr), .ext_op(s_ext_op), .alu_op(s_alu_op), .a_sel(s_a_sel),
        .b_sel(s_b_sel), .imem_req(s_imem_req), .dmem_req(s_dmem_req), .trap(s_trap),
        .trap_cause(s_trap_cause)
    );

    typedef enum int {
        SigPcWr, SigNpc, SigIrWr, SigRfWr, SigGpr, SigWd, SigDmWr, SigExt, SigAlu,
        SigASel, SigBSel, SigIreq, SigDreq, SigTrap, SigCause, SigSkipIreq, SigSkipTrap
    } sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] get_sig(input sig_e s);
        case (s)
            SigPcWr:     return {31'b0, pc_wr};
            SigNpc:      return {30'b0, npc_op};
            SigIrWr:     return {31'b0, ir_wr};
            SigRfWr:     return {31'b0, rf_wr};
            SigGpr:      return {30'b0, gpr_sel};
            SigWd:       return {30'b0, wd_sel};
            SigDmWr:     return {31'b0, dm_wr};
            SigExt:      return {30'b0, ext_op};
            SigAlu:      return {27'b0, alu_op};
            SigASel:     return {30'b0, a_sel};
            SigBSel:     return {31'b0, b_sel};
            SigIreq:     return {31'b0, imem_req};
            SigDreq:     return {31'b0, dmem_req};
            SigTrap:     return {31'b0, trap};
            SigCause:    return {30'b0, trap_cause};
            SigSkipIreq: return {31'b0, s_imem_req};
            SigSkipTrap: return {31'b0, s_trap};
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic ex(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_sig(e.sig);
            n_checks++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in FETCH cycle 0 with the wait counter cleared.
    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        zero     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Completes a 1-cycle FETCH of the given instruction; returns in DCD.
    task automatic fetch_now(input logic [5:0] o, input logic [5:0] f);
        op       = o;
        funct    = f;
        imem_ack = 1'b1;
        ex("fetch_ir_wr", SigIrWr, 1);
        ex("fetch_pc_wr", SigPcWr, 1);
        ex("fetch_npc", SigNpc, 32'(NPC_PLUS4));
        check_cycle();
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic do_branch(input string tag, input logic [5:0] o, input logic z,
                             input logic exp_pc);
        fetch_now(o, 6'h00);
        tick();
        zero = z;
        ex({tag, "_pc_wr"}, SigPcWr, {31'b0, exp_pc});
        ex({tag, "_npc"}, SigNpc, 32'(NPC_BRANCH));
        ex({tag, "_alu"}, SigAlu, 32'(ALUOp_EQL));
        ex({tag, "_ext"}, SigExt, 32'(EXT_SIGNED));
        check_cycle();
        tick();
        zero = 1'b0;
        ex({tag, "_back_fetch"}, SigIreq, 1);
        check_cycle();
    endtask

    initial begin
        do_reset();
        ex("rst_imem_req", SigIreq, 1);
        ex("rst_ir_wr", SigIrWr, 0);
        ex("rst_pc_wr", SigPcWr, 0);
        ex("rst_rf_wr", SigRfWr, 0);
        ex("rst_trap", SigTrap, 0);
        ex("rst_cause", SigCause, 0);
        check_cycle();

        // ADD with imem_ack on the fourth FETCH cycle.
        op    = OP_RTYPE;
        funct = F_ADD;
        for (int c = 0; c < 3; c++) begin
            ex("add_wait_ir_wr", SigIrWr, 0);
            ex("add_wait_pc_wr", SigPcWr, 0);
            ex("add_wait_req", SigIreq, 1);
            check_cycle();
            tick();
        end
        imem_ack = 1'b1;
        ex("add_ack_ir_wr", SigIrWr, 1);
        ex("add_ack_pc_wr", SigPcWr, 1);
        check_cycle();
        tick();
        imem_ack = 1'b0;
        ex("add_dcd_ir_wr", SigIrWr, 0);
        ex("add_dcd_req", SigIreq, 0);
        check_cycle();
        tick();
        ex("add_exe_alu", SigAlu, 32'(ALUOp_ADD));
        ex("add_exe_bsel", SigBSel, 0);
        ex("add_exe_rf_wr", SigRfWr, 0);
        check_cycle();
        tick();
        ex("add_wb_rf_wr", SigRfWr, 1);
        ex("add_wb_gpr", SigGpr, 32'(GPRSel_RD));
        ex("add_wb_wd", SigWd, 32'(WDSel_FromALU));
        check_cycle();
        tick();
        ex("add_next_fetch", SigIreq, 1);
        ex("add_next_rf_wr", SigRfWr, 0);
        check_cycle();

        // LUI exercise of the constant-16 A operand.
        fetch_now(OP_LUI, 6'h00);
        tick();
        ex("lui_alu", SigAlu, 32'(ALUOp_SLL));
        ex("lui_asel", SigASel, 32'(ASEL_C16));
        ex("lui_bsel", SigBSel, 1);
        check_cycle();
        tick();
        ex("lui_wb_gpr", SigGpr, 32'(GPRSel_RT));
        check_cycle();
        tick();

        // LW with dmem_ack on the sixth MR cycle.
        fetch_now(OP_LW, 6'h00);
        tick();
        ex("lw_ma_alu", SigAlu, 32'(ALUOp_ADDU));
        ex("lw_ma_bsel", SigBSel, 1);
        ex("lw_ma_ext", SigExt, 32'(EXT_SIGNED));
        check_cycle();
        tick();
        for (int c = 0; c < 5; c++) begin
            ex("lw_wait_dreq", SigDreq, 1);
            ex("lw_wait_dm_wr", SigDmWr, 0);
            ex("lw_wait_rf_wr", SigRfWr, 0);
            check_cycle();
            tick();
        end
        dmem_ack = 1'b1;
        ex("lw_ack_dreq", SigDreq, 1);
        ex("lw_ack_dm_wr", SigDmWr, 0);
        check_cycle();
        tick();
        dmem_ack = 1'b0;
        ex("lw_memwb_rf_wr", SigRfWr, 1);
        ex("lw_memwb_gpr", SigGpr, 32'(GPRSel_RT));
        ex("lw_memwb_wd", SigWd, 32'(WDSel_FromMEM));
        ex("lw_memwb_dreq", SigDreq, 0);
        check_cycle();
        tick();

        // SW with immediate ack.
        fetch_now(OP_SW, 6'h00);
        tick();
        tick();
        dmem_ack = 1'b1;
        ex("sw_dreq", SigDreq, 1);
        ex("sw_dm_wr", SigDmWr, 1);
        check_cycle();
        tick();
        dmem_ack = 1'b0;
        ex("sw_next_fetch", SigIreq, 1);
        ex("sw_next_rf_wr", SigRfWr, 0);
        check_cycle();

        do_branch("bne_z1", OP_BNE, 1'b1, 1'b0);
        do_branch("bne_z0", OP_BNE, 1'b0, 1'b1);
        do_branch("beq_z1", OP_BEQ, 1'b1, 1'b1);
        do_branch("beq_z0", OP_BEQ, 1'b0, 1'b0);

        fetch_now(OP_JAL, 6'h00);
        tick();
        ex("jal_pc_wr", SigPcWr, 1);
        ex("jal_npc", SigNpc, 32'(NPC_JUMP));
        ex("jal_rf_wr", SigRfWr, 1);
        ex("jal_gpr", SigGpr, 32'(GPRSel_31));
        ex("jal_wd", SigWd, 32'(WDSel_FromPC));
        check_cycle();
        tick();

        fetch_now(OP_RTYPE, F_JR);
        tick();
        ex("jr_pc_wr", SigPcWr, 1);
        ex("jr_npc", SigNpc, 32'(NPC_JMPR));
        ex("jr_rf_wr", SigRfWr, 0);
        check_cycle();
        tick();
        ex("jr_next_fetch", SigIreq, 1);
        check_cycle();

        fetch_now(OP_RTYPE, F_JALR);
        tick();
        ex("jalr_pc_wr", SigPcWr, 1);
        ex("jalr_npc", SigNpc, 32'(NPC_JMPR));
        ex("jalr_rf_wr", SigRfWr, 1);
        ex("jalr_gpr", SigGpr, 32'(GPRSel_RD));
        ex("jalr_wd", SigWd, 32'(WDSel_FromPC));
        check_cycle();
        tick();

        // imem never acks: 16 FETCH cycles then TRAP with cause 2.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            ex("ito_wait_req", SigIreq, 1);
            ex("ito_wait_trap", SigTrap, 0);
            check_cycle();
            tick();
        end
        ex("ito_trap", SigTrap, 1);
        ex("ito_cause", SigCause, 32'(CauseImemTo));
        ex("ito_req_off", SigIreq, 0);
        check_cycle();
        tick();
        ex("ito_trap_held", SigTrap, 1);
        check_cycle();

        // Ack exactly on the last allowed cycle wins over the timeout.
        do_reset();
        op    = OP_RTYPE;
        funct = F_ADD;
        for (int c = 0; c < 15; c++) tick();
        imem_ack = 1'b1;
        ex("ack15_ir_wr", SigIrWr, 1);
        check_cycle();
        tick();
        imem_ack = 1'b0;
        ex("ack15_no_trap", SigTrap, 0);
        ex("ack15_req_off", SigIreq, 0);
        check_cycle();

        // dmem never acks on a load: trap with cause 3.
        do_reset();
        fetch_now(OP_LW, 6'h00);
        tick();
        tick();
        for (int c = 0; c < 16; c++) begin
            ex("dto_wait_dreq", SigDreq, 1);
            check_cycle();
            tick();
        end
        ex("dto_trap", SigTrap, 1);
        ex("dto_cause", SigCause, 32'(CauseDmemTo));
        ex("dto_dreq_off", SigDreq, 0);
        check_cycle();

        // Illegal opcode: trapping instance traps, skipping instance refetches.
        do_reset();
        fetch_now(6'h3F, 6'h00);
        tick();
        ex("ill_trap", SigTrap, 1);
        ex("ill_cause", SigCause, 32'(CauseIllegal));
        ex("ill_req_off", SigIreq, 0);
        ex("ill_skip_req", SigSkipIreq, 1);
        ex("ill_skip_trap", SigSkipTrap, 0);
        check_cycle();
        do_reset();
        ex("ill_rst_trap", SigTrap, 0);
        ex("ill_rst_cause", SigCause, 0);
        ex("ill_rst_req", SigIreq, 1);
        check_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
